// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter_bank timer peripheral: register map,
// count modes, CTRL field positions and the channel-address width helper.
package counter_bank_pkg;

    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CTRL_PRE_LO  = 8;

    function automatic int chan_bits(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/counter_chan.sv
// One timer channel: tick edge detect, prescaler, down-counter with
// one-shot / periodic / square terminal behaviour and a sticky done flag.
module counter_chan
    import counter_bank_pkg::*;
#(
    parameter int W     = 32,
    parameter int PRE_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load_we,
    input  logic         ctrl_we,
    input  logic         status_we,
    input  logic [31:0]  wdata,
    output logic [W-1:0] load,
    output logic [W-1:0] count,
    output logic [31:0]  ctrl,
    output logic         done,
    output logic         out,
    output logic         irq_req
);

    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0]     load_reg;
    logic [W-1:0]     count_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [PRE_W-1:0] pre_reg;
    mode_e            mode_reg;
    logic             en_reg;
    logic             irq_en_reg;
    logic             done_reg;
    logic             out_reg;
    logic             pulse_reg;
    logic             tick_prev_reg;

    logic evt;
    logic step;
    logic terminal;

    assign evt      = tick & ~tick_prev_reg & en_reg;
    assign step     = evt && (pre_cnt_reg == pre_reg);
    assign terminal = step && (count_reg == CNT_ONE);

    always_ff @(posedge clk) begin
        // History follows tick even in reset, so a level already high at release is not an edge.
        tick_prev_reg <= tick;
        if (!rst) begin
            load_reg    <= '0;
            count_reg   <= '0;
            pre_cnt_reg <= '0;
            pre_reg     <= '0;
            mode_reg    <= MODE_ONESHOT;
            en_reg      <= 1'b0;
            irq_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            out_reg     <= 1'b0;
            pulse_reg   <= 1'b0;
        end else begin
            if (pulse_reg) begin
                out_reg   <= 1'b0;
                pulse_reg <= 1'b0;
            end
            if (ctrl_we) begin
                en_reg     <= wdata[CTRL_EN];
                mode_reg   <= mode_e'(wdata[CTRL_MODE_LO +: 2]);
                irq_en_reg <= wdata[CTRL_IRQ_EN];
                pre_reg    <= wdata[CTRL_PRE_LO +: PRE_W];
            end
            if (status_we && wdata[0]) begin
                done_reg <= 1'b0;
            end
            // A LOAD write overrides any step in the same cycle; a terminal step overrides a done clear.
            if (load_we) begin
                load_reg    <= wdata[W-1:0];
                count_reg   <= wdata[W-1:0];
                pre_cnt_reg <= '0;
                out_reg     <= 1'b0;
                pulse_reg   <= 1'b0;
                done_reg    <= 1'b0;
            end else if (evt) begin
                if (step) begin
                    pre_cnt_reg <= '0;
                    if (terminal) begin
                        done_reg <= 1'b1;
                        case (mode_reg)
                            MODE_PERIODIC: begin
                                count_reg <= load_reg;
                                out_reg   <= 1'b1;
                                pulse_reg <= 1'b1;
                            end
                            MODE_SQUARE: begin
                                count_reg <= load_reg;
                                out_reg   <= ~out_reg;
                            end
                            default: begin
                                count_reg <= '0;
                                out_reg   <= 1'b1;
                            end
                        endcase
                    end else if (count_reg > CNT_ONE) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end else begin
                    pre_cnt_reg <= pre_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ctrl                             = '0;
        ctrl[CTRL_EN]                    = en_reg;
        ctrl[CTRL_MODE_LO +: 2]          = mode_reg;
        ctrl[CTRL_IRQ_EN]                = irq_en_reg;
        ctrl[CTRL_PRE_LO +: PRE_W]       = pre_reg;
    end

    assign load    = load_reg;
    assign count   = count_reg;
    assign done    = done_reg;
    assign out     = out_reg;
    assign irq_req = done_reg & irq_en_reg;

endmodule

// File: rtl/counter_bank.sv
// Multi-channel timer/counter: register decode, per-channel write strobes,
// combinational read mux and the combined interrupt.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int  CH    = 3,
    parameter int  W     = 32,
    parameter int  PRE_W = 8,
    localparam int CHW   = chan_bits(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   tick,
    input  logic            we,
    input  logic [CHW+1:0]  addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [CH-1:0]   out,
    output logic            irq
);

    logic [CHW-1:0] sel_chan;
    logic [1:0]     sel_reg;
    logic [31:0]    rd_chan [2**CHW];
    logic [CH-1:0]  irq_vec;

    assign sel_chan = addr[CHW+1:2];
    assign sel_reg  = addr[1:0];

    // Address slots beyond CH exist but decode to nothing and read as zero.
    generate
        for (genvar gi = 0; gi < 2**CHW; gi++) begin : g_slot
            if (gi < CH) begin : g_chan
                logic          hit;
                logic [W-1:0]  load_v;
                logic [W-1:0]  count_v;
                logic [31:0]   ctrl_v;
                logic          done_v;

                assign hit = we && (sel_chan == CHW'(gi));

                counter_chan #(
                    .W     (W),
                    .PRE_W (PRE_W)
                ) u_chan (
                    .clk       (clk),
                    .rst       (rst),
                    .tick      (tick[gi]),
                    .load_we   (hit && (sel_reg == REG_LOAD)),
                    .ctrl_we   (hit && (sel_reg == REG_CTRL)),
                    .status_we (hit && (sel_reg == REG_STATUS)),
                    .wdata     (wdata),
                    .load      (load_v),
                    .count     (count_v),
                    .ctrl      (ctrl_v),
                    .done      (done_v),
                    .out       (out[gi]),
                    .irq_req   (irq_vec[gi])
                );

                assign rd_chan[gi] = (sel_reg == REG_LOAD)  ? 32'(load_v)  :
                                     (sel_reg == REG_CTRL)  ? ctrl_v       :
                                     (sel_reg == REG_COUNT) ? 32'(count_v) :
                                                              {31'd0, done_v};
            end else begin : g_empty
                assign rd_chan[gi] = '0;
            end
        end
    endgenerate

    assign rdata = rd_chan[sel_chan];
    assign irq   = |irq_vec;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_counter_bank;
    import counter_bank_pkg::*;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_IRQ = 2;
    localparam int K_RD2 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  tick;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  out;
    logic        irq;

    logic [4:0]  tick2;
    logic        we2;
    logic [4:0]  addr2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic [4:0]  out2;
    logic        irq2;

    always #5 clk = ~clk;

    counter_bank #(.CH(3), .W(32), .PRE_W(8)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .out(out), .irq(irq)
    );

    counter_bank #(.CH(5), .W(16), .PRE_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick2), .we(we2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .out(out2), .irq(irq2)
    );

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] act;
    int          errors = 0;
    int          checks = 0;
    logic        chk_req = 1'b0;
    logic        done_sim = 1'b0;

    always @(negedge clk) begin
        if (chk_req) begin
            while (sb.size() > 0) begin
                cur = sb.pop_front();
                case (cur.kind)
                    K_RD:    act = rdata;
                    K_OUT:   act = 32'(out);
                    K_IRQ:   act = 32'(irq);
                    default: act = rdata2;
                endcase
                checks++;
                if (act !== cur.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", cur.name, act, cur.exp);
                end else begin
                    $display("ok   %s: 0x%0h", cur.name, act);
                end
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        if (!done_sim) begin
            errors++;
            $display("FAIL timeout: stimulus did not finish within 5000 cycles");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic check_now(input logic [31:0] a, input logic [31:0] e, input string n);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end else begin
            $display("ok   %s: 0x%0h", n, a);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    function automatic logic [3:0] ra(input int ch, input int r);
        return 4'(ch * 4 + r);
    endfunction

    task automatic push_exp(input int kind, input logic [31:0] e, input string n);
        exp_t item;
        item.kind = kind;
        item.exp  = e;
        item.name = n;
        sb.push_back(item);
        chk_req = 1'b1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        addr  = ra(ch, r);
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] e, input string n);
        addr = ra(ch, r);
        push_exp(K_RD, e, n);
        step();
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        addr2  = a;
        wdata2 = d;
        we2    = 1'b1;
        step();
        we2    = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a, input logic [31:0] e, input string n);
        addr2 = a;
        push_exp(K_RD2, e, n);
        step();
    endtask

    // Tick high for one cycle; caller must keep it low for at least one cycle after.
    task automatic pulse(input int ch);
        tick[ch] = 1'b1;
        step();
        tick[ch] = 1'b0;
    endtask

    task automatic ticks(input int ch, input int n);
        repeat (n) begin
            pulse(ch);
            step();
        end
    endtask

    initial begin
        rst = 1'b0; tick = '0; we = 1'b0; addr = '0; wdata = '0;
        tick2 = '0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        step();

        // Activity during reset must be ignored.
        addr = ra(0, REG_LOAD); wdata = 32'd5; we = 1'b1; tick = 3'b111;
        step();
        we = 1'b0; tick = 3'b000;
        step();
        tick = 3'b111;
        step();
        tick = 3'b000;
        check_now(32'(out), 32'h0, "rst_out");
        check_now(32'(irq), 32'h0, "rst_irq");
        rd(0, REG_LOAD,   32'h0, "rst_load");
        rd(0, REG_CTRL,   32'h0, "rst_ctrl");
        rd(0, REG_COUNT,  32'h0, "rst_count");
        rd(0, REG_STATUS, 32'h0, "rst_status");
        rst = 1'b1;
        step();

        // One-shot on channel 0.
        wr(0, REG_LOAD, 32'd3);
        wr(0, REG_CTRL, 32'h9);
        rd(0, REG_CTRL,  32'h9, "os_ctrl");
        rd(0, REG_COUNT, 32'd3, "os_count_load");
        pulse(0);
        rd(0, REG_COUNT, 32'd2, "os_count_2");
        pulse(0);
        rd(0, REG_COUNT, 32'd1, "os_count_1");
        pulse(0);
        push_exp(K_OUT, 32'h1, "os_out");
        push_exp(K_IRQ, 32'h1, "os_irq");
        rd(0, REG_COUNT,  32'd0, "os_count_0");
        rd(0, REG_STATUS, 32'd1, "os_done");
        pulse(0);
        rd(0, REG_COUNT, 32'd0, "os_stopped");
        wr(0, REG_STATUS, 32'h1);
        push_exp(K_IRQ, 32'h0, "os_irq_clr");
        push_exp(K_OUT, 32'h1, "os_out_held");
        rd(0, REG_STATUS, 32'd0, "os_done_clr");

        // Periodic on channel 1, prescaler 2.
        wr(1, REG_LOAD, 32'd2);
        wr(1, REG_CTRL, 32'h203);
        ticks(1, 3);
        rd(1, REG_COUNT, 32'd1, "per_count_e3");
        ticks(1, 2);
        rd(1, REG_COUNT, 32'd1, "per_count_e5");
        pulse(1);
        push_exp(K_OUT, 32'h3, "per_out_pulse");
        rd(1, REG_COUNT, 32'd2, "per_reload");
        push_exp(K_OUT, 32'h1, "per_out_end");
        push_exp(K_IRQ, 32'h0, "per_irq_masked");
        rd(1, REG_STATUS, 32'd1, "per_done");

        // Square on channel 2.
        wr(2, REG_LOAD, 32'd1);
        wr(2, REG_CTRL, 32'h5);
        for (int k = 0; k < 4; k++) begin
            pulse(2);
            push_exp(K_OUT, (k % 2 == 0) ? 32'h5 : 32'h1, $sformatf("sq_out_%0d", k));
            push_exp(K_IRQ, 32'h0, $sformatf("sq_irq_%0d", k));
            rd(2, REG_COUNT, 32'd1, $sformatf("sq_count_%0d", k));
        end
        wr(2, REG_STATUS, 32'h0);
        rd(2, REG_STATUS, 32'd1, "sq_done_sticky");

        // LOAD write on the terminal edge wins.
        wr(0, REG_LOAD, 32'd1);
        tick[0] = 1'b1; addr = ra(0, REG_LOAD); wdata = 32'd7; we = 1'b1;
        step();
        tick[0] = 1'b0; we = 1'b0;
        push_exp(K_OUT, 32'h0, "col_load_out");
        rd(0, REG_COUNT,  32'd7, "col_load_count");
        rd(0, REG_STATUS, 32'd0, "col_load_done");

        // STATUS clear on the terminal edge loses to the set.
        wr(0, REG_LOAD, 32'd1);
        tick[0] = 1'b1; addr = ra(0, REG_STATUS); wdata = 32'h1; we = 1'b1;
        step();
        tick[0] = 1'b0; we = 1'b0;
        push_exp(K_IRQ, 32'h1, "col_clr_irq");
        rd(0, REG_STATUS, 32'd1, "col_clr_done");

        // Disable freezes the count; re-enable resumes.
        wr(0, REG_LOAD, 32'd10);
        ticks(0, 2);
        rd(0, REG_COUNT, 32'd8, "frz_before");
        wr(0, REG_CTRL, 32'h8);
        ticks(0, 5);
        rd(0, REG_COUNT, 32'd8, "frz_gap");
        wr(0, REG_CTRL, 32'h9);
        ticks(0, 1);
        rd(0, REG_COUNT, 32'd7, "frz_resume");

        // CTRL write coinciding with a step: the step uses the old CTRL.
        tick[0] = 1'b1; addr = ra(0, REG_CTRL); wdata = 32'h8; we = 1'b1;
        step();
        tick[0] = 1'b0; we = 1'b0;
        rd(0, REG_COUNT, 32'd6, "ctrl_same_cycle");
        ticks(0, 1);
        rd(0, REG_COUNT, 32'd6, "ctrl_now_off");

        // CH=5, W=16 instance: absent channel and LOAD truncation.
        wr2(5'd28, 32'h1234);
        rd2(5'd28, 32'h0, "b_ch7_load");
        rd2(5'd29, 32'h0, "b_ch7_ctrl");
        wr2(5'd16, 32'h1FFFF);
        rd2(5'd16, 32'hFFFF, "b_ch4_load");
        rd2(5'd18, 32'hFFFF, "b_ch4_count");

        // Reset mid-count.
        wr(0, REG_CTRL, 32'h9);
        rst = 1'b0;
        step();
        rst = 1'b1;
        push_exp(K_OUT, 32'h0, "rstm_out");
        rd(0, REG_COUNT, 32'd0, "rstm_count");
        rd(0, REG_LOAD,  32'd0, "rstm_load");
        rd(0, REG_CTRL,  32'd0, "rstm_ctrl");

        step();
        step();
        done_sim = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
